// File: rtl/wu_fetch_pkg.sv
`default_nettype none
// wu_fetch_pkg: shared widths and FSM encoding for the WU instruction fetch stage.
// Rev 1.0
package wu_fetch_pkg;

   localparam int MGR_WU_ADDRESS_RANGE = 10;
   localparam int WUF_CNT_RANGE        = MGR_WU_ADDRESS_RANGE + 1;
   localparam int MGR_MGR_ID_W         = 8;

   typedef enum logic [1:0] {
      WUF_IDLE  = 2'd0,
      WUF_FETCH = 2'd1,
      WUF_DONE  = 2'd2
   } wuf_state_e;

endpackage
`default_nettype wire

// File: rtl/wu_fetch_counter.sv
`default_nettype none
// wu_fetch_counter: fetch address / remaining-instruction counter pair.
// Rev 1.0
module wu_fetch_counter
   import wu_fetch_pkg::*;
#(
   parameter int ADDR_W = MGR_WU_ADDRESS_RANGE,
   parameter int CNT_W  = WUF_CNT_RANGE
) (
   input  logic              clk,
   input  logic              reset_poweron,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [CNT_W-1:0]  load_cnt_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [CNT_W-1:0]  remaining_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;

   always_comb begin
      addr_d      = addr_q;
      remaining_d = remaining_q;
      if (load_i) begin
         addr_d      = load_addr_i;
         remaining_d = load_cnt_i;
      end else if (step_i) begin
         // Address wraps naturally at the top of the WU memory.
         addr_d      = addr_q + 1'b1;
         remaining_d = remaining_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
      end
   end

   assign addr_o      = addr_q;
   assign remaining_o = remaining_q;

endmodule
`default_nettype wire

// File: rtl/wu_fetch.sv
`default_nettype none
// wu_fetch: WU instruction fetch stage; issues sequential reads to WU memory per run.
// Rev 1.0
module wu_fetch
   import wu_fetch_pkg::*;
#(
   parameter int ADDR_W = MGR_WU_ADDRESS_RANGE,
   parameter int CNT_W  = ADDR_W + 1,
   parameter int ID_W   = MGR_MGR_ID_W
) (
   input  logic              clk,
   input  logic              reset_poweron,
   input  logic [ID_W-1:0]   sys__mgr__mgrId,
   input  logic              seq__wuf__start,
   input  logic [ADDR_W-1:0] seq__wuf__start_addr,
   input  logic [CNT_W-1:0]  seq__wuf__num_inst,
   output logic              wuf__seq__busy,
   output logic              wuf__seq__done,
   output logic              wuf__seq__aborted,
   input  logic              wud__wuf__abort,
   output logic [ADDR_W-1:0] wuf__wum__addr,
   output logic              wuf__wum__read,
   input  logic              wum__wuf__stall,
   output logic [ID_W-1:0]   wuf__dbg__mgrId
);

   wuf_state_e        state_q, state_d;
   logic              abort_flag_q, abort_flag_d;
   logic              issue;
   logic              load;
   logic [ADDR_W-1:0] addr_cnt;
   logic [CNT_W-1:0]  remaining;

   logic              read_q;
   logic [ADDR_W-1:0] addr_out_q;
   logic              busy_q;
   logic              done_q;
   logic              aborted_q;
   logic [ID_W-1:0]   mgr_id_q;

   assign load = (state_q == WUF_IDLE) && seq__wuf__start;

   wu_fetch_counter #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_counter (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .load_i        (load),
      .load_addr_i   (seq__wuf__start_addr),
      .load_cnt_i    (seq__wuf__num_inst),
      .step_i        (issue),
      .addr_o        (addr_cnt),
      .remaining_o   (remaining)
   );

   always_comb begin
      state_d      = state_q;
      abort_flag_d = abort_flag_q;
      issue        = 1'b0;
      case (state_q)
         WUF_IDLE: begin
            if (seq__wuf__start) begin
               abort_flag_d = 1'b0;
               state_d      = (seq__wuf__num_inst == '0) ? WUF_DONE : WUF_FETCH;
            end
         end
         WUF_FETCH: begin
            // Abort wins over a coincident issue, including the final one.
            if (wud__wuf__abort) begin
               abort_flag_d = 1'b1;
               state_d      = WUF_DONE;
            end else if (!wum__wuf__stall && (remaining != '0)) begin
               issue = 1'b1;
               if (remaining == CNT_W'(1)) begin
                  state_d = WUF_DONE;
               end
            end
         end
         WUF_DONE: state_d = WUF_IDLE;
         default:  state_d = WUF_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         state_q      <= WUF_IDLE;
         abort_flag_q <= 1'b0;
         read_q       <= 1'b0;
         addr_out_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         mgr_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         abort_flag_q <= abort_flag_d;
         read_q       <= issue;
         if (issue) begin
            addr_out_q <= addr_cnt;
         end
         // Busy stays up through the cycle the done pulse is visible.
         busy_q       <= (state_d != WUF_IDLE) || (state_q == WUF_DONE);
         done_q       <= (state_q == WUF_DONE);
         aborted_q    <= (state_q == WUF_DONE) && abort_flag_q;
         mgr_id_q     <= sys__mgr__mgrId;
      end
   end

   assign wuf__wum__read    = read_q;
   assign wuf__wum__addr    = addr_out_q;
   assign wuf__seq__busy    = busy_q;
   assign wuf__seq__done    = done_q;
   assign wuf__seq__aborted = aborted_q;
   assign wuf__dbg__mgrId   = mgr_id_q;

endmodule
`default_nettype wire

// File: tb/tb_wu_fetch.sv
`default_nettype none
// tb_wu_fetch: directed and random checks of wu_fetch against a run-level reference model.
// Rev 1.0
module tb_wu_fetch;

   localparam int ADDR_W = 10;
   localparam int CNT_W  = 11;
   localparam int ID_W   = 8;

   logic              clk = 1'b0;
   logic              reset_poweron;
   logic [ID_W-1:0]   mgr_id;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [CNT_W-1:0]  num_inst;
   logic              busy, done, aborted;
   logic              abort;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd;
   logic              stall;
   logic [ID_W-1:0]   dbg_id;

   always #5 clk = ~clk;

   wu_fetch #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
      .clk                  (clk),
      .reset_poweron        (reset_poweron),
      .sys__mgr__mgrId      (mgr_id),
      .seq__wuf__start      (start),
      .seq__wuf__start_addr (start_addr),
      .seq__wuf__num_inst   (num_inst),
      .wuf__seq__busy       (busy),
      .wuf__seq__done       (done),
      .wuf__seq__aborted    (aborted),
      .wud__wuf__abort      (abort),
      .wuf__wum__addr       (rd_addr),
      .wuf__wum__read       (rd),
      .wum__wuf__stall      (stall),
      .wuf__dbg__mgrId      (dbg_id)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a run is "idle", "running" (issued < total) or "finishing".
   int                m_phase, m_prev, m_total, m_issued;
   logic [ADDR_W-1:0] m_base;
   bit                m_ab;
   logic              e_read, e_busy, e_done, e_abt;
   logic [ADDR_W-1:0] e_addr;
   logic [ID_W-1:0]   e_dbg;

   always @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         m_phase = 0; m_total = 0; m_issued = 0; m_base = '0; m_ab = 1'b0;
         e_read = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_abt = 1'b0;
         e_addr = '0; e_dbg = '0;
      end else begin
         m_prev = m_phase;
         e_dbg  = mgr_id;
         e_read = 1'b0;
         e_done = (m_prev == 2);
         e_abt  = (m_prev == 2) && m_ab;
         case (m_prev)
            0: if (start) begin
                  m_base   = start_addr;
                  m_total  = int'(num_inst);
                  m_issued = 0;
                  m_ab     = 1'b0;
                  m_phase  = (m_total == 0) ? 2 : 1;
               end
            1: if (abort) begin
                  m_ab    = 1'b1;
                  m_phase = 2;
               end else if (!stall) begin
                  e_read = 1'b1;
                  e_addr = ADDR_W'((32'(m_base) + m_issued) % (1 << ADDR_W));
                  m_issued++;
                  if (m_issued == m_total) m_phase = 2;
               end
            default: m_phase = 0;
         endcase
         e_busy = (m_phase != 0) || (m_prev == 2);
      end
   end

   int                cyc = 0;
   int                done_cnt = 0;
   logic              last_abt = 1'b0;
   logic [ADDR_W-1:0] rd_log[$];
   int                rd_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("read",    32'(rd),      32'(e_read));
         chk("addr",    32'(rd_addr), 32'(e_addr));
         chk("busy",    32'(busy),    32'(e_busy));
         chk("done",    32'(done),    32'(e_done));
         chk("aborted", 32'(aborted), 32'(e_abt));
         chk("dbg_id",  32'(dbg_id),  32'(e_dbg));
      end
      if (rd) begin
         rd_log.push_back(rd_addr);
         rd_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         last_abt = aborted;
      end
   end

   int done_base;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
      done_base  = done_cnt;
      start      = 1'b1;
      start_addr = a;
      num_inst   = n;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int max, input string nm);
      int k = 0;
      while (done_cnt == done_base && k < max) begin
         tick();
         k++;
      end
      chk({nm, "_timeout"}, 32'(done_cnt != done_base), 32'd1);
      tick();
      tick();
   endtask

   task automatic check_reads(input string nm, input int n, input logic [ADDR_W-1:0] first);
      logic [ADDR_W-1:0] a;
      chk({nm, "_nreads"}, 32'(rd_log.size()), 32'(n));
      a = first;
      for (int i = 0; i < n; i++) begin
         chk({nm, "_addr"}, 32'(rd_log[i]), 32'(a));
         a = a + 1'b1;
      end
   endtask

   task automatic run_abort(input logic [ADDR_W-1:0] a, input int k, input string nm);
      int  rc = 0;
      bit  fired = 1'b0;
      rd_log.delete();
      stall = 1'b0;
      start_pulse(a, 11'd8);
      for (int i = 0; i < 40 && done_cnt == done_base; i++) begin
         tick();
         if (rd) rc++;
         abort = (rc == k) && !fired;
         if (abort) fired = 1'b1;
      end
      abort = 1'b0;
      wait_done(10, nm);
      check_reads(nm, k, a);
      chk({nm, "_aborted"}, 32'(last_abt), 32'd1);
   endtask

   initial begin
      logic [7:0]        pat;
      logic [ADDR_W-1:0] wrap_exp [4];
      int                k;
      int                d0;
      int                rc;

      reset_poweron = 1'b0;
      stall = 1'b1; start = 1'b0; start_addr = '0; num_inst = '0;
      abort = 1'b0; mgr_id = 8'h5A;
      #2 chk_en = 1'b1;
      tick(); tick(); tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_read", 32'(rd), 32'd0);
      chk("rst_dbg",  32'(dbg_id), 32'd0);
      reset_poweron = 1'b1;
      tick();

      // Basic run: stall released two cycles after start.
      rd_log.delete(); rd_cyc.delete();
      start_pulse(10'h010, 11'd4);
      tick();
      stall = 1'b0;
      wait_done(40, "t1");
      check_reads("t1", 4, 10'h010);
      chk("t1_consec", 32'(rd_cyc[3] - rd_cyc[0]), 32'd3);
      chk("t1_aborted", 32'(last_abt), 32'd0);

      // Address wrap at the top of memory.
      rd_log.delete();
      wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      start_pulse(10'h3FE, 11'd4);
      wait_done(40, "t2");
      chk("t2_nreads", 32'(rd_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("t2_addr", 32'(rd_log[i]), 32'(wrap_exp[i]));

      // Stall toggling 0,1,1,0,0,1,0,1 repeating.
      rd_log.delete();
      pat = 8'b1010_0110;
      stall = 1'b0;
      start_pulse(10'h100, 11'd6);
      for (int i = 0; i < 60 && done_cnt == done_base; i++) begin
         stall = pat[i % 8];
         tick();
      end
      stall = 1'b0;
      wait_done(10, "t3");
      check_reads("t3", 6, 10'h100);

      // Aborts: after the 3rd read, and coincident with the final issue.
      run_abort(10'h080, 3, "t4a");
      run_abort(10'h0C0, 7, "t4b");

      // Zero-length run: done two cycles after the start cycle, no reads.
      rd_log.delete();
      start_pulse(10'h123, 11'd0);
      k = 1;
      while (!done && k < 10) begin
         tick();
         k++;
      end
      chk("t5_done_lat", 32'(k), 32'd2);
      tick(); tick();
      chk("t5_nreads", 32'(rd_log.size()), 32'd0);
      chk("t5_aborted", 32'(last_abt), 32'd0);

      // A start during FETCH must not disturb the run.
      rd_log.delete();
      start_pulse(10'h040, 11'd5);
      tick();
      start_pulse(10'h200, 11'd1);
      done_base = done_cnt;
      wait_done(40, "t5b");
      check_reads("t5b", 5, 10'h040);

      // Reset mid-run: outputs drop immediately, no done pulse.
      rd_log.delete();
      start_pulse(10'h050, 11'd5);
      rc = 0;
      for (int i = 0; i < 20 && rc < 2; i++) begin
         tick();
         if (rd) rc++;
      end
      chk("t6_two_reads", 32'(rc), 32'd2);
      d0 = done_cnt;
      #2 reset_poweron = 1'b0;
      #1;
      chk("t6_async_busy", 32'(busy), 32'd0);
      chk("t6_async_read", 32'(rd), 32'd0);
      tick(); tick();
      reset_poweron = 1'b1;
      tick(); tick(); tick(); tick();
      chk("t6_no_done", 32'(done_cnt), 32'(d0));
      rd_log.delete();
      start_pulse(10'h020, 11'd1);
      wait_done(20, "t6");
      check_reads("t6", 1, 10'h020);

      // Random traffic; the per-cycle compare does the checking.
      for (int i = 0; i < 4000; i++) begin
         stall      = ($urandom_range(0, 3) == 0);
         start      = ($urandom_range(0, 9) == 0);
         start_addr = ADDR_W'($urandom);
         num_inst   = CNT_W'($urandom_range(0, 12));
         abort      = ($urandom_range(0, 31) == 0);
         mgr_id     = ID_W'($urandom);
         tick();
      end
      start = 1'b0; abort = 1'b0; stall = 1'b0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wu_fetch.md
Name: wu_fetch

Overview:
- Work-unit (WU) instruction fetch stage of the manager. It sits directly upstream of the WU instruction memory and drives its read address and read strobe.
- Each fetch run is started by the manager's WU sequencer with a start address and an instruction count. The block then issues sequential reads while the memory is not stalling.
- The WU decoder can abort a run early, for example on a terminating instruction.

Parameters:
- ADDR_W, 10, width of the WU instruction memory address; matches MGR_WU_ADDRESS_RANGE.
- CNT_W, 11, width of the instruction-count field; must be ADDR_W+1 so a full-memory run is expressible.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_poweron  input  1  asynchronous, active-low reset.
- sys__mgr__mgrId  input  MGR_MGR_ID width  manager ID; registered and exported for debug only.
- seq__wuf__start  input  1  single-cycle start request.
- seq__wuf__start_addr  input  ADDR_W  first instruction address; sampled with start.
- seq__wuf__num_inst  input  CNT_W  number of instructions to fetch; sampled with start.
- wuf__seq__busy  output  1  high while a run is in progress.
- wuf__seq__done  output  1  single-cycle pulse at end of run.
- wuf__seq__aborted  output  1  valid with done; 1 if the run ended by abort.
- wud__wuf__abort  input  1  single-cycle abort request from the decoder.
- wuf__wum__addr  output  ADDR_W  read address to WU memory.
- wuf__wum__read  output  1  read strobe; one instruction per cycle it is high.
- wum__wuf__stall  input  1  registered stall from WU memory; high out of reset.
- wuf__dbg__mgrId  output  MGR_MGR_ID width  registered copy of sys__mgr__mgrId.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE.
  - addr_q=0, remaining=0.
  - All outputs 0.
  - A reset mid-run discards the run with no done pulse.
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - busy=0.
  - On start: load addr_q=start_addr and remaining=num_inst.
  - If num_inst==0, go to DONE with aborted=0 and issue no reads.
  - Otherwise go to FETCH.
  - Abort in IDLE is ignored.
- FETCH:
  - busy=1.
  - Issue condition, evaluated each cycle: issue = (wum__wuf__stall==0) && (remaining!=0) && !abort.
  - Registered outputs: on the next edge read<=issue and addr<=addr_q. Read strobe and address therefore appear one cycle after stall is sampled low.
  - On issue: addr_q <= addr_q+1, wrapping modulo 2^ADDR_W (all-ones -> 0); remaining <= remaining-1.
  - After the issue that makes remaining 0: go to DONE, aborted=0.
  - On abort: go to DONE, aborted=1, no further reads. An abort arriving in the same cycle as the final issue suppresses that issue and reports aborted=1.
  - Stall high: hold addr_q and remaining, read<=0. There is no stall timeout.
  - Start while busy is ignored and not queued.
- DONE:
  - Lasts one cycle.
  - done=1, busy=1, read=0.
  - Next state is IDLE.
  - A start in the DONE cycle is ignored; the sequencer waits for busy=0.
- Throughput: one read per cycle while stall stays low.
- Read count: exactly num_inst reads per uninterrupted run.
- Address: wuf__wum__addr holds its last value while read=0; the downstream stage qualifies it with read.
- Count arithmetic: unsigned. remaining never underflows because issue requires remaining!=0.

Decomposition:
- Shared package/header wu_fetch.vh:
  - FSM state encoding: WUF_IDLE=2'd0, WUF_FETCH=2'd1, WUF_DONE=2'd2.
  - WUF_CNT_RANGE.
  - Address width tied to MGR_WU_ADDRESS_RANGE.
- Single module; no sub-module needed.
- The address/remaining counter pair may optionally be split out as wuf_addr_counter.

Test Plan:
- Reset with stall=1, then start(addr=0x010, n=4) with stall low from cycle 3 -> reads at addresses 0x010..0x013 on 4 consecutive cycles. Then done=1 for one cycle with aborted=0, and busy=0 the following cycle.
- Start(addr=0x3FE, n=4), ADDR_W=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001, then done.
- Start(n=6) with stall toggled 0,1,1,0,0,1,0,... -> read is high exactly one cycle after each stall-low sample, addresses strictly sequential, 6 reads total, done after the 6th.
- Start(n=8) with abort asserted after the 3rd read -> no further reads, done=1 with aborted=1. Also check abort coincident with the final issue -> 7 reads, aborted=1.
- Start(n=0) -> zero reads, done pulse two cycles after start. A start pulse during FETCH leaves addr and count unchanged.
- Assert reset mid-run (after 2 of 5 reads) -> read=0 and busy=0 immediately (asynchronously), no done pulse. After release, a new start(addr=0x020, n=1) fetches address 0x020 only.
